// File: rtl/uart_rx_if.sv
// uart_rx_if: receive-byte handshake bundle between uart_rx and its consumer.
// master = receiver (drives byte/status), slave = consumer (drives data_ack_i).
interface uart_rx_if;
  logic [7:0] data_o;
  logic       data_valid_o;
  logic       data_ack_i;
  logic       frame_err_o;
  logic       overrun_o;
  logic       busy_o;

  modport master (
    output data_o,
    output data_valid_o,
    output frame_err_o,
    output overrun_o,
    output busy_o,
    input  data_ack_i
  );

  modport slave (
    input  data_o,
    input  data_valid_o,
    input  frame_err_o,
    input  overrun_o,
    input  busy_o,
    output data_ack_i
  );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver on a shared 16x oversampling tick.
// Ports: clk_i, rst_i (sync, active-high), tick_i (oversample strobe),
//   rxd_i (async line, idle high), bus (uart_rx_if.master):
//   data_o, data_valid_o, data_ack_i, frame_err_o, overrun_o, busy_o.
// Option: RX_MAJORITY_EN -> decision samples use 3-tick majority vote.
module uart_rx #(
  parameter int SYNC_STAGES   = 2,
  parameter int TICKS_PER_BIT = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        tick_i,
  input  logic        rxd_i,
  uart_rx_if.master   bus
);

  localparam int CW = $clog2(TICKS_PER_BIT);
  localparam logic [CW-1:0] MID  = CW'(TICKS_PER_BIT/2 - 1);
  localparam logic [CW-1:0] LAST = CW'(TICKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t                 r_state;
  logic [SYNC_STAGES-1:0] r_sync;
  logic [CW-1:0]          r_tick_cnt;
  logic [2:0]             r_bit_cnt;
  logic [7:0]             r_shreg;
  logic [7:0]             r_data;
  logic                   r_valid;
  logic                   r_ferr;
  logic                   r_ovr;
  logic                   r_busy;

  logic w_rxd_s;
  logic w_sample;
  logic w_deliver;

  always_ff @(posedge clk_i) begin
    if (rst_i) r_sync <= '1;
    else       r_sync <= {r_sync[SYNC_STAGES-2:0], rxd_i};
  end

  assign w_rxd_s = r_sync[SYNC_STAGES-1];

`ifdef RX_MAJORITY_EN
  // Two previous tick captures plus the current one form the 3-bit window.
  logic [1:0] r_win;
  logic [2:0] w_win;

  always_ff @(posedge clk_i) begin
    if (rst_i)       r_win <= 2'b11;
    else if (tick_i) r_win <= {r_win[0], w_rxd_s};
  end

  assign w_win    = {r_win, w_rxd_s};
  assign w_sample = (w_win[0] & w_win[1]) |
                    (w_win[0] & w_win[2]) |
                    (w_win[1] & w_win[2]);
`else
  assign w_sample = w_rxd_s;
`endif

  assign w_deliver = tick_i && (r_state == STOP) &&
                     (r_tick_cnt == LAST) && w_sample;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= IDLE;
      r_tick_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shreg    <= '0;
      r_busy     <= 1'b0;
      r_ferr     <= 1'b0;
    end else begin
      r_ferr <= 1'b0;
      if (tick_i) begin
        unique case (r_state)
          IDLE: begin
            if (!w_rxd_s) begin
              r_state    <= START;
              r_tick_cnt <= '0;
              r_busy     <= 1'b1;
            end
          end
          START: begin
            if (r_tick_cnt == MID) begin
              r_tick_cnt <= '0;
              r_bit_cnt  <= '0;
              if (!w_sample) begin
                r_state <= DATA;
              end else begin
                r_state <= IDLE;
                r_busy  <= 1'b0;
              end
            end else begin
              r_tick_cnt <= r_tick_cnt + 1'b1;
            end
          end
          DATA: begin
            if (r_tick_cnt == LAST) begin
              r_tick_cnt <= '0;
              r_shreg    <= {w_sample, r_shreg[7:1]};
              r_bit_cnt  <= r_bit_cnt + 3'd1;
              if (r_bit_cnt == 3'd7) r_state <= STOP;
            end else begin
              r_tick_cnt <= r_tick_cnt + 1'b1;
            end
          end
          STOP: begin
            if (r_tick_cnt == LAST) begin
              // Leave at mid stop bit so a back-to-back start is caught.
              r_tick_cnt <= '0;
              r_state    <= IDLE;
              r_busy     <= 1'b0;
              r_ferr     <= !w_sample;
            end else begin
              r_tick_cnt <= r_tick_cnt + 1'b1;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  // Handshake runs every clock; delivery outranks a plain ack.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_data  <= 8'h00;
      r_valid <= 1'b0;
      r_ovr   <= 1'b0;
    end else if (w_deliver) begin
      r_data  <= r_shreg;
      r_valid <= 1'b1;
      if (r_valid && !bus.data_ack_i) r_ovr <= 1'b1;
    end else if (bus.data_ack_i && r_valid) begin
      r_valid <= 1'b0;
      r_ovr   <= 1'b0;
    end
  end

  assign bus.data_o       = r_data;
  assign bus.data_valid_o = r_valid;
  assign bus.frame_err_o  = r_ferr;
  assign bus.overrun_o    = r_ovr;
  assign bus.busy_o       = r_busy;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed table-driven bench for uart_rx.
// Ticks every 2nd clock; frames built tick by tick from the bench side.
module tb_uart_rx;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tick = 1'b0;
  logic rxd = 1'b1;

  uart_rx_if u_if ();

  uart_rx dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .tick_i (tick),
    .rxd_i  (rxd),
    .bus    (u_if.master)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  int ferr_cnt = 0;

  always @(negedge clk)
    if (u_if.frame_err_o) ferr_cnt <= ferr_cnt + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); tick = 1'b1;
      @(negedge clk); tick = 1'b0;
    end
  endtask

  task automatic ack();
    @(negedge clk); u_if.data_ack_i = 1'b1;
    @(negedge clk); u_if.data_ack_i = 1'b0;
  endtask

  // One frame = 160 tick periods; ack/glitch/abort/pause at a tick index.
  task automatic send_frame(input logic [7:0] b, input logic stp,
                            input int ack_at, input int glitch_at,
                            input int abort_at, input int pause_at);
    logic v;
    for (int t = 0; t < 160; t++) begin
      if (t == abort_at) begin
        rst = 1'b1;
        @(negedge clk); rst = 1'b0; rxd = 1'b1;
        return;
      end
      if (t == pause_at) repeat (40) @(negedge clk);
      if (t < 16)       v = 1'b0;
      else if (t < 144) v = b[(t-16)/16];
      else              v = stp;
      if (t == glitch_at) v = 1'b0;
      @(negedge clk);
      rxd = v; tick = 1'b1;
      u_if.data_ack_i = (t == ack_at);
      @(negedge clk);
      tick = 1'b0; u_if.data_ack_i = 1'b0;
    end
    rxd = 1'b1;
    idle(12);
  endtask

  typedef struct {
    logic [7:0] b;
    logic       stp;
    logic [7:0] exp_data;
    logic       exp_valid;
    int         exp_ferr;
  } vec_t;

  vec_t vecs[6];
  int f0;
  logic [7:0] glitch_exp;

  initial begin
    u_if.data_ack_i = 1'b0;
    vecs[0] = '{8'hA5, 1'b1, 8'hA5, 1'b1, 0};
    vecs[1] = '{8'h3C, 1'b0, 8'hA5, 1'b0, 1};
    vecs[2] = '{8'h00, 1'b1, 8'h00, 1'b1, 0};
    vecs[3] = '{8'hFF, 1'b1, 8'hFF, 1'b1, 0};
    vecs[4] = '{8'h81, 1'b0, 8'hFF, 1'b0, 1};
    vecs[5] = '{8'hC3, 1'b1, 8'hC3, 1'b1, 0};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_data",  32'(u_if.data_o), 32'h00);
    chk("rst_valid", 32'(u_if.data_valid_o), 0);
    chk("rst_ferr",  32'(u_if.frame_err_o), 0);
    chk("rst_ovr",   32'(u_if.overrun_o), 0);
    chk("rst_busy",  32'(u_if.busy_o), 0);

    f0 = ferr_cnt;
    rxd = 1'b0; idle(4);
    chk("fs_busy_in", 32'(u_if.busy_o), 1);
    rxd = 1'b1; idle(12);
    chk("fs_busy_out", 32'(u_if.busy_o), 0);
    chk("fs_valid", 32'(u_if.data_valid_o), 0);
    chk("fs_ferr", 32'(ferr_cnt - f0), 0);

    for (int i = 0; i < 6; i++) begin
      f0 = ferr_cnt;
      send_frame(vecs[i].b, vecs[i].stp, -1, -1, -1, -1);
      chk($sformatf("v%0d_data", i), 32'(u_if.data_o),
          32'(vecs[i].exp_data));
      chk($sformatf("v%0d_valid", i), 32'(u_if.data_valid_o),
          32'(vecs[i].exp_valid));
      chk($sformatf("v%0d_ferr", i), 32'(ferr_cnt - f0),
          32'(vecs[i].exp_ferr));
      chk($sformatf("v%0d_ovr", i), 32'(u_if.overrun_o), 0);
      chk($sformatf("v%0d_busy", i), 32'(u_if.busy_o), 0);
      if (vecs[i].exp_valid) begin
        ack();
        chk($sformatf("v%0d_ack", i), 32'(u_if.data_valid_o), 0);
      end
    end

    send_frame(8'h11, 1'b1, -1, -1, -1, -1);
    send_frame(8'h22, 1'b1, -1, -1, -1, -1);
    chk("ovr_data",  32'(u_if.data_o), 32'h22);
    chk("ovr_valid", 32'(u_if.data_valid_o), 1);
    chk("ovr_set",   32'(u_if.overrun_o), 1);
    ack();
    chk("ovr_ack_valid", 32'(u_if.data_valid_o), 0);
    chk("ovr_ack_clr",   32'(u_if.overrun_o), 0);
    send_frame(8'h11, 1'b1, -1, -1, -1, -1);
    send_frame(8'h22, 1'b1, 153, -1, -1, -1);
    chk("sameclk_data",  32'(u_if.data_o), 32'h22);
    chk("sameclk_valid", 32'(u_if.data_valid_o), 1);
    chk("sameclk_ovr",   32'(u_if.overrun_o), 0);
    ack();

`ifdef RX_MAJORITY_EN
    glitch_exp = 8'hFF;
`else
    glitch_exp = 8'hFD;
`endif
    send_frame(8'hFF, 1'b1, -1, 40, -1, -1);
    chk("glitch_data",  32'(u_if.data_o), 32'(glitch_exp));
    chk("glitch_valid", 32'(u_if.data_valid_o), 1);
    ack();

    f0 = ferr_cnt;
    send_frame(8'h5A, 1'b1, -1, -1, 88, -1);
    chk("abort_busy",  32'(u_if.busy_o), 0);
    chk("abort_valid", 32'(u_if.data_valid_o), 0);
    chk("abort_data",  32'(u_if.data_o), 32'h00);
    idle(20);
    chk("abort_idle_valid", 32'(u_if.data_valid_o), 0);
    chk("abort_idle_ovr",   32'(u_if.overrun_o), 0);
    send_frame(8'h96, 1'b1, -1, -1, -1, 70);
    chk("post_data",  32'(u_if.data_o), 32'h96);
    chk("post_valid", 32'(u_if.data_valid_o), 1);
    chk("post_ferr",  32'(ferr_cnt - f0), 0);
    chk("post_ovr",   32'(u_if.overrun_o), 0);
    ack();

    f0 = ferr_cnt;
    rxd = 1'b0; idle(306);
    rxd = 1'b1; idle(12);
    chk("brk_ferr",  32'(ferr_cnt - f0), 2);
    chk("brk_valid", 32'(u_if.data_valid_o), 0);
    chk("brk_busy",  32'(u_if.busy_o), 0);
    chk("brk_data",  32'(u_if.data_o), 32'h96);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver: the receive end of the 8N1 link (1 start, 8 data LSB-first, 1 stop).
- Shares the 16x-oversampling tick_i strobe with the transmit side.
- Synchronises the raw line, validates the start bit and mid-bit samples each data bit.
- Checks the stop bit and presents the byte through a valid/ack handshake with overrun and framing-error reporting.

Parameters:
- SYNC_STAGES, 2, number of flops in the rxd_i synchroniser (min 2).
- TICKS_PER_BIT, 16, tick_i strobes per bit period; the mid-bit point is TICKS_PER_BIT/2-1.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  synchronous active-high reset
- tick_i  in  1  one-clk strobe at 16x baud
- rxd_i  in  1  asynchronous serial line, idle high
- data_ack_i  in  1  consumer has taken data_o; clears data_valid_o
- data_o  out  8  received byte
- data_valid_o  out  1  byte available; held until acked
- frame_err_o  out  1  one-clk pulse: stop bit sampled low
- overrun_o  out  1  sticky: new byte delivered while data_valid_o was still set
- busy_o  out  1  receiver in a frame (state != IDLE)

Behaviour:
- Interface: one clock clk_i; rst_i is synchronous, active-high.
- Reset values:
  - All synchroniser flops = 1.
  - State = IDLE.
  - data_o = 0x00; data_valid_o, frame_err_o, overrun_o, busy_o = 0.
  - tick_cnt, bit_cnt and shift register = 0.
- Reset mid-frame aborts the frame immediately; the partial byte is never delivered.
- rxd_s is the synchroniser output. All decisions use rxd_s.
- All state and counter updates happen only on clocks with tick_i=1, except the handshake logic, which runs every clock.
- FSM states:
  - IDLE: tick with rxd_s=0 -> START, tick_cnt=0.
  - START: each tick, tick_cnt++. At tick_cnt==7 (mid start bit):
    - sample=0 -> DATA, tick_cnt=0, bit_cnt=0.
    - sample=1 -> IDLE (false start); no flags raised.
  - DATA: each tick, tick_cnt++ (4-bit, wraps 15->0). At tick_cnt==15, sample and shift: shreg <= {sample, shreg[7:1]}, bit_cnt++. When the 8th bit is shifted -> STOP.
  - STOP: at tick_cnt==15, sample, then -> IDLE.
    - sample=1: deliver shreg.
    - sample=0: pulse frame_err_o for exactly one clk; shreg discarded; data_o and data_valid_o unchanged.
- Returning to IDLE at mid stop bit allows a back-to-back next start edge to be caught.
- Latency: data_valid_o rises on the clock after the tick on which the stop bit is sampled.
- Delivery and handshake (priority as listed):
  - Delivery with data_valid_o=0: data_o <= shreg, data_valid_o <= 1.
  - Delivery with data_valid_o=1 and no data_ack_i: data_o overwritten with the new byte, data_valid_o stays 1, overrun_o <= 1.
  - Delivery with data_ack_i in the same clk: new byte loaded, data_valid_o stays 1, overrun_o not set.
  - data_ack_i with no delivery: data_valid_o <= 0, overrun_o <= 0.
  - data_ack_i while data_valid_o=0: no effect.
- tick_i held low: FSM and counters freeze; no timeout.
- rxd_i stuck low (break): repeated frame_err_o pulses, one per frame time; no delivery.

Optional Feature:
- Macro: RX_MAJORITY_EN.
- Defined:
  - A 3-bit window captures rxd_s on every tick.
  - The sample used at each decision point (START mid, each DATA bit, STOP) is the majority of the last 3 tick captures.
  - Start detection in IDLE still uses a single low sample.
- Undefined: the sample is rxd_s at the decision tick. No window logic is synthesised.

Test Plan:
- Frame 0xA5 at 16 ticks/bit, stop=1 -> data_valid_o=1, data_o=0xA5, frame_err_o=0, busy_o=0 after the frame.
- rxd_i low for 4 ticks, then high -> no data_valid_o, busy_o returns to 0 at START mid-point, no frame_err_o.
- Frame 0x3C with stop bit=0 -> frame_err_o single-clk pulse, data_valid_o stays 0, data_o unchanged.
- Frames 0x11 then 0x22, no ack -> data_o=0x22, data_valid_o=1, overrun_o=1. Then ack -> both cleared. Repeat with ack in the same clk as the 0x22 delivery -> overrun_o=0.
- Frame 0xFF with a 1-tick low glitch at the mid-point of data bit 1:
  - RX_MAJORITY_EN defined -> data_o=0xFF.
  - Undefined -> data_o=0xFD.
- rst_i asserted at data bit 4 of 0x5A, then a clean 0x96 frame -> nothing delivered from the aborted frame, then data_o=0x96, all flags 0 in between.
